// File: rtl/ascon_pkg.sv
// Shared constants for the masked Ascon permutation sequencer: geometry,
// lane offsets, round-constant table and FSM encoding.
package ascon_pkg;

    localparam int STATE_W = 320;
    localparam int LANE_W  = 64;
    localparam int RC_NUM  = 12;

    localparam int S0 = 0;
    localparam int S1 = 1;
    localparam int S2 = 2;
    localparam int S3 = 3;
    localparam int S4 = 4;

    localparam int S0_OFF = S0 * LANE_W;
    localparam int S1_OFF = S1 * LANE_W;
    localparam int S2_OFF = S2 * LANE_W;
    localparam int S3_OFF = S3 * LANE_W;
    localparam int S4_OFF = S4 * LANE_W;

    // Round constant lands in the low byte of lane S2.
    localparam int RC_BIT_OFF = S2_OFF;

    localparam logic [7:0] RC [0:RC_NUM-1] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_ISSUE = 2'd1;
    localparam logic [1:0] FSM_WAIT  = 2'd2;
    localparam logic [1:0] FSM_DONE  = 2'd3;

    // Indices past the table (idx == RC_NUM after the last round) yield zero.
    function automatic logic [7:0] rc_lookup(input logic [3:0] idx);
        logic [7:0] rc;
        rc = 8'h00;
        for (int i = 0; i < RC_NUM; i++) begin
            if (idx == 4'(i)) begin
                rc = RC[i];
            end
        end
        return rc;
    endfunction

endpackage

// File: rtl/ascon_rc_inject.sv
// Round-constant injection into share A, lane S2 low byte.
// Latency: combinational. Backpressure: none, pure function of inputs.
// Share B is never touched here, so the shares stay separate.
module ascon_rc_inject
    import ascon_pkg::*;
(
    input  logic [3:0]         idx,
    input  logic [STATE_W-1:0] share_a,
    output logic [STATE_W-1:0] share_a_rc
);

    logic [7:0] rc;

    always_comb begin
        rc         = rc_lookup(idx);
        share_a_rc = share_a;
        share_a_rc[RC_BIT_OFF +: 8] = share_a[RC_BIT_OFF +: 8] ^ rc;
    end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Two-share masked Ascon permutation sequencer driving an external round core.
// Latency: start to done_o = 1 + (1 + CORE_LAT) * n cycles plus randomness stalls.
// Backpressure: start_i ignored while not IDLE; stalls in ISSUE until rand_valid_i.
module ascon_perm_ctrl
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS = 12,
    parameter int CORE_LAT   = 2,
    parameter int RAND_W     = 320
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [3:0]           rounds_i,
    input  logic [STATE_W-1:0]   state_A_i,
    input  logic [STATE_W-1:0]   state_B_i,
    input  logic [RAND_W-1:0]    rand_i,
    input  logic                 rand_valid_i,
    output logic                 rand_req_o,
    output logic [STATE_W-1:0]   core_A_o,
    output logic [STATE_W-1:0]   core_B_o,
    output logic [RAND_W-1:0]    core_rand_o,
    input  logic [STATE_W-1:0]   core_A_i,
    input  logic [STATE_W-1:0]   core_B_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [STATE_W-1:0]   state_A_o,
    output logic [STATE_W-1:0]   state_B_o
);

    localparam int         CNT_W = $clog2(CORE_LAT + 1);
    localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

    logic [1:0]         fsm_q;
    logic [STATE_W-1:0] st_a_q;
    logic [STATE_W-1:0] st_b_q;
    logic [3:0]         idx_q;
    logic [CNT_W-1:0]   wait_q;
    logic [STATE_W-1:0] out_a_q;
    logic [STATE_W-1:0] out_b_q;

    logic [3:0]         n_rounds;
    logic [3:0]         idx_inc;
    logic               issue_fire;
    logic [STATE_W-1:0] inj_a;

    always_comb begin
        n_rounds = rounds_i;
        if (rounds_i > MAX_R) begin
            n_rounds = MAX_R;
        end
    end

    assign idx_inc    = idx_q + 4'd1;
    assign issue_fire = (fsm_q == FSM_ISSUE) && rand_valid_i;

    ascon_rc_inject u_rc_inject (
        .idx        (idx_q),
        .share_a    (st_a_q),
        .share_a_rc (inj_a)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q   <= FSM_IDLE;
            st_a_q  <= '0;
            st_b_q  <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            case (fsm_q)
                FSM_IDLE: begin
                    if (start_i) begin
                        st_a_q <= state_A_i;
                        st_b_q <= state_B_i;
                        idx_q  <= MAX_R - n_rounds;
                        if (n_rounds == 4'd0) begin
                            // Zero rounds: the input state is the result.
                            fsm_q   <= FSM_DONE;
                            out_a_q <= state_A_i;
                            out_b_q <= state_B_i;
                        end else begin
                            fsm_q <= FSM_ISSUE;
                        end
                    end
                end
                FSM_ISSUE: begin
                    if (rand_valid_i) begin
                        fsm_q  <= FSM_WAIT;
                        wait_q <= CNT_W'(CORE_LAT);
                    end
                end
                FSM_WAIT: begin
                    wait_q <= wait_q - CNT_W'(1);
                    if (wait_q == CNT_W'(1)) begin
                        st_a_q <= core_A_i;
                        st_b_q <= core_B_i;
                        idx_q  <= idx_inc;
                        if (idx_inc == MAX_R) begin
                            fsm_q   <= FSM_DONE;
                            out_a_q <= core_A_i;
                            out_b_q <= core_B_i;
                        end else begin
                            fsm_q <= FSM_ISSUE;
                        end
                    end
                end
                default: begin
                    fsm_q <= FSM_IDLE;
                end
            endcase
        end
    end

    // Core inputs are forced to zero except on the accepted ISSUE cycle.
    assign core_A_o    = issue_fire ? inj_a  : '0;
    assign core_B_o    = issue_fire ? st_b_q : '0;
    assign core_rand_o = issue_fire ? rand_i : '0;

    assign rand_req_o = (fsm_q == FSM_ISSUE);
    assign busy_o     = (fsm_q == FSM_ISSUE) || (fsm_q == FSM_WAIT);
    assign done_o     = (fsm_q == FSM_DONE);
    assign state_A_o  = out_a_q;
    assign state_B_o  = out_b_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Scoreboard bench for ascon_perm_ctrl with a stub round core (identity or
// masked Ascon round) and a reference permutation computed from the round rules.
module tb_ascon_perm_ctrl;

    localparam int SW = 320;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [3:0]    rounds_i = '0;
    logic [SW-1:0] state_A_i = '0;
    logic [SW-1:0] state_B_i = '0;
    logic [SW-1:0] rand_i = '0;
    logic          rand_valid_i = 1'b1;
    logic          rand_req_o;
    logic [SW-1:0] core_A_o, core_B_o, core_rand_o;
    logic [SW-1:0] core_A_i, core_B_i;
    logic          busy_o, done_o;
    logic [SW-1:0] state_A_o, state_B_o;

    ascon_perm_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .rounds_i     (rounds_i),
        .state_A_i    (state_A_i),
        .state_B_i    (state_B_i),
        .rand_i       (rand_i),
        .rand_valid_i (rand_valid_i),
        .rand_req_o   (rand_req_o),
        .core_A_o     (core_A_o),
        .core_B_o     (core_B_o),
        .core_rand_o  (core_rand_o),
        .core_A_i     (core_A_i),
        .core_B_i     (core_B_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .state_A_o    (state_A_o),
        .state_B_o    (state_B_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    task automatic chk(input string name, input logic ok, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference Ascon round ----------------
    function automatic logic [63:0] ror(input logic [63:0] x, input int s);
        return (x >> s) | (x << (64 - s));
    endfunction

    function automatic logic [7:0] rc(input int r);
        return 8'(240 - 15 * r);
    endfunction

    // Substitution layer followed by linear diffusion (no constant).
    function automatic logic [SW-1:0] round_fn(input logic [SW-1:0] s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[63:0]; x1 = s[127:64]; x2 = s[191:128]; x3 = s[255:192]; x4 = s[319:256];
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic logic [SW-1:0] ref_perm(input logic [SW-1:0] s, input int n);
        logic [SW-1:0] t;
        t = s;
        for (int r = 12 - n; r < 12; r++) begin
            t[135:128] = t[135:128] ^ rc(r);
            t = round_fn(t);
        end
        return t;
    endfunction

    function automatic logic [SW-1:0] rnd320();
        logic [SW-1:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- stub round core: 2-cycle pipe ----------------
    logic          core_mode = 1'b0;   // 0: identity, 1: masked Ascon round
    logic [SW-1:0] p1a, p1b, p2a, p2b;
    always @(posedge clk) begin
        if (rst_i) begin
            p1a <= '0; p1b <= '0; p2a <= '0; p2b <= '0;
        end else begin
            if (core_mode) begin
                p1a <= round_fn(core_A_o ^ core_B_o) ^ core_rand_o;
                p1b <= core_rand_o;
            end else begin
                p1a <= core_A_o;
                p1b <= core_B_o;
            end
            p2a <= p1a;
            p2b <= p1b;
        end
    end
    assign core_A_i = p2a;
    assign core_B_i = p2b;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic          chk_xor;
        logic [SW-1:0] ea;
        logic [SW-1:0] eb;
        int            ecyc;
    } done_exp_t;

    typedef struct {
        logic [SW-1:0] ea;
        logic [SW-1:0] eb;
    } iss_exp_t;

    done_exp_t done_q[$];
    iss_exp_t  iss_q[$];
    done_exp_t de;
    iss_exp_t  ie;

    always @(negedge clk) begin
        if (!rst_i) begin
            if (rand_req_o && rand_valid_i) begin
                chk("issue_busy", busy_o == 1'b1, SW'(busy_o), SW'(1));
                chk("issue_rand", core_rand_o == rand_i, core_rand_o, rand_i);
                if (!core_mode) begin
                    if (iss_q.size() == 0) begin
                        chk("issue_unexpected", 1'b0, core_A_o, '0);
                    end else begin
                        ie = iss_q.pop_front();
                        chk("issue_core_a", core_A_o == ie.ea, core_A_o, ie.ea);
                        chk("issue_core_b", core_B_o == ie.eb, core_B_o, ie.eb);
                    end
                end
            end else begin
                chk("core_idle_zero", (core_A_o | core_B_o | core_rand_o) == '0,
                    core_A_o | core_B_o | core_rand_o, '0);
            end
            if (done_o) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 1'b0, SW'(done_o), SW'(0));
                end else begin
                    de = done_q.pop_front();
                    chk("done_cycle", cyc == de.ecyc, SW'(cyc), SW'(de.ecyc));
                    chk("done_busy", busy_o == 1'b0, SW'(busy_o), SW'(0));
                    if (de.chk_xor) begin
                        chk("result_xor", (state_A_o ^ state_B_o) == de.ea, state_A_o ^ state_B_o, de.ea);
                    end else begin
                        chk("result_a", state_A_o == de.ea, state_A_o, de.ea);
                        chk("result_b", state_B_o == de.eb, state_B_o, de.eb);
                    end
                end
                done_seen++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_perm(input logic mode, input logic [3:0] rnds,
                            input logic [SW-1:0] a, input logic [SW-1:0] b,
                            input int st_round, input int st_len,
                            input logic pulse_busy, input int rst_round);
        int        n, c0, d0, stall, limit;
        logic      finished;
        logic [SW-1:0] acc;
        iss_exp_t  ix;
        done_exp_t dx;

        n     = (rnds > 4'd12) ? 12 : int'(rnds);
        stall = (st_len > 0 && st_round < n) ? st_len : 0;
        @(posedge clk); #1;
        core_mode    = mode;
        start_i      = 1'b1;
        rounds_i     = rnds;
        state_A_i    = a;
        state_B_i    = b;
        rand_valid_i = 1'b1;
        rand_i       = rnd320();
        c0 = cyc;
        d0 = done_seen;

        acc = a;
        if (!mode) begin
            for (int r = 12 - n; r < 12; r++) begin
                acc[135:128] = acc[135:128] ^ rc(r);
                ix.ea = acc;
                ix.eb = b;
                iss_q.push_back(ix);
            end
        end
        dx.ecyc = c0 + 1 + 3 * n + stall;
        if (mode && n > 0) begin
            dx.chk_xor = 1'b1;
            dx.ea      = ref_perm(a ^ b, n);
            dx.eb      = '0;
        end else begin
            dx.chk_xor = 1'b0;
            dx.ea      = acc;
            dx.eb      = b;
        end
        if (rst_round < 0) done_q.push_back(dx);

        finished = 1'b0;
        limit    = 3 * n + stall + 10;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            if (done_seen != d0) begin
                finished = 1'b1;
                break;
            end
            start_i = pulse_busy && (k == 4);
            if (start_i) begin
                rounds_i  = 4'($urandom_range(0, 15));
                state_A_i = rnd320();
                state_B_i = rnd320();
            end
            rand_i       = rnd320();
            rand_valid_i = !(stall > 0 && k >= 1 + 3 * st_round && k < 1 + 3 * st_round + stall);
            if (rst_round >= 0 && k == 2 + 3 * rst_round) begin
                rst_i        = 1'b1;
                rand_valid_i = 1'b1;
                done_q.delete();
                iss_q.delete();
                @(posedge clk); #1;
                rst_i = 1'b0;
                @(negedge clk);
                chk("rst_ctrl", {busy_o, done_o, rand_req_o} == 3'b000,
                    SW'({busy_o, done_o, rand_req_o}), SW'(0));
                chk("rst_core_a", core_A_o == '0, core_A_o, '0);
                chk("rst_core_b", core_B_o == '0, core_B_o, '0);
                chk("rst_core_rand", core_rand_o == '0, core_rand_o, '0);
                chk("rst_state_a", state_A_o == '0, state_A_o, '0);
                chk("rst_state_b", state_B_o == '0, state_B_o, '0);
                // Any done_o after the abort is caught as unexpected by the monitor.
                repeat (3 * n + 5) @(posedge clk);
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            chk("done_timeout", 1'b0, SW'(done_seen - d0), SW'(1));
        end
        start_i      = 1'b0;
        rand_valid_i = 1'b1;
    endtask

    logic [SW-1:0] test_state;
    logic [SW-1:0] mask;

    initial begin
        test_state = {64'h08090a0b0c0d0e0f, 64'h0001020304050607,
                      64'hf0e0d0c0b0a09080, 64'h0123456789abcdef, 64'h80400c0600000000};

        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {busy_o, done_o, rand_req_o} == 3'b000,
            SW'({busy_o, done_o, rand_req_o}), SW'(0));
        chk("reset_core", (core_A_o | core_B_o | core_rand_o) == '0, core_A_o | core_B_o | core_rand_o, '0);
        chk("reset_state_a", state_A_o == '0, state_A_o, '0);
        chk("reset_state_b", state_B_o == '0, state_B_o, '0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Single round, identity core, zero state.
        run_perm(1'b0, 4'd1, '0, '0, 0, 0, 1'b0, -1);
        // Full p^12 with the masked round core, unmasked and masked input.
        run_perm(1'b1, 4'd12, test_state, '0, 0, 0, 1'b0, -1);
        mask = rnd320();
        run_perm(1'b1, 4'd12, test_state ^ mask, mask, 0, 0, 1'b0, -1);
        // Six rounds, identity core: constant order and accumulated S2 byte.
        run_perm(1'b0, 4'd6, '0, '0, 0, 0, 1'b0, -1);
        // Randomness stall of 5 cycles in round 3.
        run_perm(1'b1, 4'd12, test_state, '0, 2, 5, 1'b0, -1);
        run_perm(1'b0, 4'd12, rnd320(), rnd320(), 2, 5, 1'b0, -1);
        // start_i while busy is ignored.
        run_perm(1'b1, 4'd12, test_state, '0, 0, 0, 1'b1, -1);
        // Reset in the first WAIT cycle of round 7, then a fresh start.
        run_perm(1'b0, 4'd12, rnd320(), rnd320(), 0, 0, 1'b0, 6);
        run_perm(1'b0, 4'd12, rnd320(), rnd320(), 0, 0, 1'b0, -1);
        // Zero rounds pass through; 15 clamps to 12.
        run_perm(1'b1, 4'd0, rnd320(), rnd320(), 0, 0, 1'b0, -1);
        run_perm(1'b1, 4'd15, test_state, rnd320(), 0, 0, 1'b0, -1);
        run_perm(1'b0, 4'd15, rnd320(), rnd320(), 0, 0, 1'b0, -1);

        for (int i = 0; i < 12; i++) begin
            run_perm(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd320(), rnd320(),
                     int'($urandom_range(0, 11)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1);
        end

        repeat (4) @(posedge clk);
        if (done_q.size() != 0 || iss_q.size() != 0) begin
            chk("scoreboard_drained", 1'b0, SW'(done_q.size() + iss_q.size()), SW'(0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
